// File: rtl/if_stage.sv
// MIPS32 instruction-fetch stage: owns the fetch PC, issues credit-limited word requests
// to instruction memory and queues returned words for decode.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] Instruction,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;

  logic [31:0]     fetchPc, respPc;
  logic [31:0]     pcMem    [FIFO_DEPTH];
  logic [31:0]     instrMem [FIFO_DEPTH];
  logic [PtrW-1:0] rdPtr, wrPtr;
  logic [CntW-1:0] count, outstanding, dropCnt;

  logic            pop, grant, rspOk, push;
  logic [SumW-1:0] inFlight;
  logic [31:0]     alignedRedirect;
  logic            unusedBits;

  assign alignedRedirect = {redirect_pc[31:2], 2'b00};
  assign unusedBits      = ^redirect_pc[1:0];

  assign id_valid = (count != '0);
  assign pop      = id_valid & id_ready & ~redirect;

  // Credit includes the same-cycle pop so a full queue draining at 1/cycle keeps fetching.
  assign inFlight = SumW'(outstanding) + SumW'(count) - SumW'(pop);
  assign imem_req = rst_n & ~redirect & (inFlight < SumW'(FIFO_DEPTH));
  assign imem_addr = fetchPc;
  assign grant    = imem_req & imem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored entirely.
  assign rspOk = imem_rvalid & (outstanding != '0);
  assign push  = rspOk & ~redirect & (dropCnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      rdPtr       <= '0;
      wrPtr       <= '0;
      count       <= '0;
      outstanding <= '0;
      dropCnt     <= '0;
    end else begin
      outstanding <= outstanding + CntW'(grant) - CntW'(rspOk);
      if (redirect) begin
        fetchPc <= alignedRedirect;
        respPc  <= alignedRedirect;
        rdPtr   <= '0;
        wrPtr   <= '0;
        count   <= '0;
        dropCnt <= outstanding - CntW'(rspOk);
      end else begin
        if (grant) fetchPc <= fetchPc + 32'd4;
        if (rspOk && (dropCnt != '0)) dropCnt <= dropCnt - 1'b1;
        if (push) begin
          wrPtr  <= wrPtr + 1'b1;
          respPc <= respPc + 32'd4;
        end
        if (pop) rdPtr <= rdPtr + 1'b1;
        count <= count + CntW'(push) - CntW'(pop);
      end
    end
  end

  // Queue storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      pcMem[wrPtr]    <= respPc;
      instrMem[wrPtr] <= imem_rdata;
    end
  end

  always_comb begin
    Instruction = '0;
    id_pc       = '0;
    id_pc_plus4 = '0;
    if (id_valid) begin
      Instruction = instrMem[rdPtr];
      id_pc       = pcMem[rdPtr];
      id_pc_plus4 = pcMem[rdPtr] + 32'd4;
    end
  end

endmodule
